// File: rtl/dm_resp.sv
// Data-memory responder: byte/half/word loads and stores on an internal byte-enabled word RAM.
// Latency: resp_valid 2 cycles after accept (3 when the access spans two words; errors take 2).
// Backpressure: req_ready only in IDLE; a held request waits, leaving one IDLE cycle between back-to-back requests.
module dm_resp #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int MISALIGN_EN = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [2:0]        req_dmtype,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int WA_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(4 * DEPTH_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  // Request fields captured on the accept edge; nothing else on req_* is looked at.
  typedef struct packed {
    logic              re;
    logic              we;
    logic [2:0]        dmtype;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t      state;
  req_t        lat;
  logic [31:0] hold;

  // RAM port
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_q;
  logic        ram_en;
  logic        ram_we;
  logic [WA_W-1:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wd;

  // Access geometry derived from the latched request
  logic [1:0]        off;
  logic [2:0]        size;
  logic [2:0]        span_sum;
  logic              span;
  logic [ADDR_W:0]   last_addr;
  logic              err;
  logic [3:0]        mask4;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [WA_W-1:0]   word0;
  logic [WA_W-1:0]   word1;

  // Load assembly
  logic [31:0] lo_word;
  logic [31:0] hi_word;
  logic [63:0] rd64;
  logic [31:0] raw;
  logic [31:0] ext;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  assign off      = lat.addr[1:0];
  assign span_sum = {1'b0, off} + size;
  assign span     = (span_sum > 3'd4);
  assign word0    = lat.addr[WA_W+1:2];
  assign word1    = word0 + 1'b1;

  // Access size and lane mask from the access type; illegal types are caught by err.
  always_comb begin
    size  = 3'd1;
    mask4 = 4'b0001;
    case (lat.dmtype)
      3'b000: begin size = 3'd4; mask4 = 4'b1111; end
      3'b001,
      3'b010: begin size = 3'd2; mask4 = 4'b0011; end
      default: begin size = 3'd1; mask4 = 4'b0001; end
    endcase
  end

  // Last byte touched, computed one bit wider so an access near the top of the address space cannot wrap.
  assign last_addr = {1'b0, lat.addr} + {{(ADDR_W-2){1'b0}}, size} - {{ADDR_W{1'b0}}, 1'b1};

  // Reject conditions on the latched request; a rejected request never issues a RAM beat.
  always_comb begin
    err = 1'b0;
    if (lat.re && lat.we)                 err = 1'b1;
    if (lat.dmtype > 3'b100)              err = 1'b1;
    if (last_addr > LAST_BYTE)            err = 1'b1;
    if ((MISALIGN_EN == 0) && span)       err = 1'b1;
  end

  // Store data and byte enables shifted into a two-word window: low half is beat 0, high half beat 1.
  assign be8  = {4'b0000, mask4} << off;
  assign wd64 = {32'h0, lat.wdata} << {off, 3'b000};

  // RAM beat issue: beat 0 in ACC0 (unless rejected), beat 1 on the next word in ACC1.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = word0;
    ram_be   = 4'b0000;
    ram_wd   = 32'h0;
    if (state == ACC0 && !err) begin
      ram_en   = 1'b1;
      ram_we   = lat.we;
      ram_addr = word0;
      ram_be   = be8[3:0];
      ram_wd   = wd64[31:0];
    end else if (state == ACC1) begin
      ram_en   = 1'b1;
      ram_we   = lat.we;
      ram_addr = word1;
      ram_be   = be8[7:4];
      ram_wd   = wd64[63:32];
    end
  end

  // Synchronous byte-enabled RAM; contents survive reset, and a beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rstn && ram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_we && ram_be[i]) begin
          mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
        end
      end
      ram_q <= mem[ram_addr];
    end
  end

  // Control FSM: accept in IDLE, one or two RAM beats, then a single response cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      hold       <= 32'h0;
      lat        <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          if (req_valid && (req_re || req_we)) begin
            lat.re     <= req_re;
            lat.we     <= req_we;
            lat.dmtype <= req_dmtype;
            lat.addr   <= req_addr;
            lat.wdata  <= req_wdata;
            state      <= ACC0;
          end
        end
        ACC0: begin
          if (err) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (span) begin
            state <= ACC1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end
        end
        ACC1: begin
          hold       <= ram_q;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Load assembly: spanning loads combine the held beat-0 word with beat 1, then shift the lanes down.
  always_comb begin
    lo_word = span ? hold  : ram_q;
    hi_word = span ? ram_q : 32'h0;
    rd64    = {hi_word, lo_word} >> {off, 3'b000};
    raw     = rd64[31:0];
  end

  // Sign/zero extension by access type.
  always_comb begin
    ext = 32'h0;
    case (lat.dmtype)
      3'b000: ext = raw;
      3'b001: ext = {{16{raw[15]}}, raw[15:0]};
      3'b010: ext = {16'h0, raw[15:0]};
      3'b011: ext = {{24{raw[7]}}, raw[7:0]};
      3'b100: ext = {24'h0, raw[7:0]};
      default: ext = 32'h0;
    endcase
  end

  // Read data only for successful loads, and only during the response cycle.
  assign resp_rdata = (resp_valid && !resp_err && lat.re) ? ext : 32'h0;

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: directed loads/stores, error cases, mid-operation reset, back-to-back requests.
// Two instances: dut_a splits word-crossing accesses, dut_b rejects them.
// Responses are checked against a scoreboard queue fed by the stimulus tasks.
module tb_dm_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req_valid;
  logic        sel;
  logic        req_re;
  logic        req_we;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        vld_a, rdy_a, rv_a, err_a, busy_a;
  logic [31:0] rd_a;
  logic        vld_b, rdy_b, rv_b, err_b, busy_b;
  logic [31:0] rd_b;

  assign vld_a = req_valid & ~sel;
  assign vld_b = req_valid & sel;

  dm_resp #(.ADDR_W(32), .DEPTH_WORDS(1024), .MISALIGN_EN(1)) dut_a (
    .clk(clk), .rstn(rstn), .req_valid(vld_a), .req_ready(rdy_a),
    .req_re(req_re), .req_we(req_we), .req_dmtype(req_dmtype),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(err_a), .busy(busy_a)
  );

  dm_resp #(.ADDR_W(32), .DEPTH_WORDS(1024), .MISALIGN_EN(0)) dut_b (
    .clk(clk), .rstn(rstn), .req_valid(vld_b), .req_ready(rdy_b),
    .req_re(req_re), .req_we(req_we), .req_dmtype(req_dmtype),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(err_b), .busy(busy_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Pop the oldest expectation for this instance and compare data, error flag and latency.
  task automatic mon_one(input bit on_b, input logic [31:0] rd, input logic er);
    exp_t e;
    int   n;
    n = on_b ? sb_b.size() : sb_a.size();
    if (n == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_resp_%s: rdata %h err %b with no request outstanding",
               on_b ? "b" : "a", rd, er);
      return;
    end
    if (on_b) e = sb_b.pop_front();
    else      e = sb_a.pop_front();
    chk({e.name, "/rdata"}, rd, e.rdata);
    chk({e.name, "/err"}, 32'(er), 32'(e.err));
    chk({e.name, "/lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    if (rv_a === 1'b1) mon_one(1'b0, rd_a, err_a);
    if (rv_b === 1'b1) mon_one(1'b1, rd_b, err_b);
  end

  // Present a request (req_valid stays high afterwards), wait for acceptance, push the expectation.
  task automatic issue(input bit to_b, input logic re, input logic we, input logic [2:0] dt,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input string name);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    sel        = to_b;
    req_valid  = 1'b1;
    req_re     = re;
    req_we     = we;
    req_dmtype = dt;
    req_addr   = addr;
    req_wdata  = wd;
    while (!(to_b ? rdy_b : rdy_a) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk({name, "/accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = lat;
    e.acc   = cyc + 1;
    e.name  = name;
    if (to_b) sb_b.push_back(e);
    else      sb_a.push_back(e);
    @(posedge clk);
  endtask

  task automatic st(input bit to_b, input logic [2:0] dt, input logic [31:0] addr,
                    input logic [31:0] wd, input int lat, input string name);
    issue(to_b, 1'b0, 1'b1, dt, addr, wd, 32'h0, 1'b0, lat, name);
  endtask

  task automatic ld(input bit to_b, input logic [2:0] dt, input logic [31:0] addr,
                    input logic [31:0] exp_rd, input int lat, input string name);
    issue(to_b, 1'b1, 1'b0, dt, addr, 32'h0, exp_rd, 1'b0, lat, name);
  endtask

  task automatic bad(input bit to_b, input logic re, input logic we, input logic [2:0] dt,
                     input logic [31:0] addr, input logic [31:0] wd, input string name);
    issue(to_b, re, we, dt, addr, wd, 32'h0, 1'b1, 2, name);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "/outstanding"}, 32'(sb_a.size() + sb_b.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rstn       = 1'b0;
    req_valid  = 1'b0;
    sel        = 1'b0;
    req_re     = 1'b0;
    req_we     = 1'b0;
    req_dmtype = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst/ready", 32'(rdy_a), 32'd1);
    chk("rst/busy", 32'(busy_a), 32'd0);
    chk("rst/resp_valid", 32'(rv_a), 32'd0);
    chk("rst/resp_rdata", rd_a, 32'h0);
    chk("rst/resp_err", 32'(err_a), 32'd0);
    chk("rst/ready_b", 32'(rdy_b), 32'd1);
    rstn = 1'b1;

    // Basic word store/load and extensions, issued back to back with req_valid held high.
    st(0, 3'b000, 32'h10, 32'h8899AABB, 2, "sw_10");
    st(0, 3'b000, 32'h14, 32'h00000000, 2, "sw_14");
    ld(0, 3'b000, 32'h10, 32'h8899AABB, 2, "lw_10");
    ld(0, 3'b011, 32'h13, 32'hFFFFFF88, 2, "lb_13");
    ld(0, 3'b100, 32'h13, 32'h00000088, 2, "lbu_13");
    ld(0, 3'b001, 32'h10, 32'hFFFFAABB, 2, "lh_10");
    ld(0, 3'b010, 32'h10, 32'h0000AABB, 2, "lhu_10");

    // Word-crossing half store and loads.
    st(0, 3'b001, 32'h13, 32'h00001234, 3, "sh_13_span");
    ld(0, 3'b010, 32'h13, 32'h00001234, 3, "lhu_13_span");
    ld(0, 3'b000, 32'h10, 32'h3499AABB, 2, "lw_10_after_sh");
    ld(0, 3'b000, 32'h14, 32'h00000012, 2, "lw_14_after_sh");
    ld(0, 3'b000, 32'h12, 32'h00123499, 3, "lw_12_span");

    // Rejected requests, each followed by a readback proving RAM is untouched.
    bad(0, 1'b1, 1'b1, 3'b000, 32'h10, 32'hDEADBEEF, "err_re_we");
    ld(0, 3'b000, 32'h10, 32'h3499AABB, 2, "lw_10_after_re_we");
    bad(0, 1'b0, 1'b1, 3'b111, 32'h14, 32'hFFFFFFFF, "err_dt111");
    ld(0, 3'b000, 32'h14, 32'h00000012, 2, "lw_14_after_dt111");
    st(0, 3'b000, 32'h00, 32'h11223344, 2, "sw_00");
    bad(0, 1'b0, 1'b1, 3'b000, 32'h1000, 32'hFFFFFFFF, "err_addr_4k");
    ld(0, 3'b000, 32'h00, 32'h11223344, 2, "lw_00_after_4k");
    st(0, 3'b000, 32'hFFC, 32'hCAFEF00D, 2, "sw_ffc");
    bad(0, 1'b0, 1'b1, 3'b000, 32'hFFE, 32'h00000000, "err_last_byte");
    ld(0, 3'b000, 32'hFFC, 32'hCAFEF00D, 2, "lw_ffc");
    ld(0, 3'b100, 32'hFFF, 32'h000000CA, 2, "lbu_fff");

    // Instance with splitting disabled.
    st(1, 3'b000, 32'h10, 32'h55667788, 2, "b_sw_10");
    st(1, 3'b000, 32'h14, 32'h00000000, 2, "b_sw_14");
    bad(1, 1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFFFF, "b_err_sw_11");
    ld(1, 3'b000, 32'h10, 32'h55667788, 2, "b_lw_10");
    ld(1, 3'b000, 32'h14, 32'h00000000, 2, "b_lw_14");
    ld(1, 3'b010, 32'h12, 32'h00005566, 2, "b_lhu_12");
    bad(1, 1'b1, 1'b0, 3'b010, 32'h13, 32'h0, "b_err_lhu_13");

    // Setup for the aborted spanning store.
    st(0, 3'b000, 32'h20, 32'hA0A0A0A0, 2, "sw_20");
    st(0, 3'b000, 32'h24, 32'hB0B0B0B0, 2, "sw_24");
    wait_drain("pre_abort");

    // Spanning store at 0x22, reset asserted while in the second beat cycle.
    @(negedge clk);
    sel        = 1'b0;
    req_valid  = 1'b1;
    req_re     = 1'b0;
    req_we     = 1'b1;
    req_dmtype = 3'b000;
    req_addr   = 32'h22;
    req_wdata  = 32'h11223344;
    n = 0;
    while (!rdy_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort/accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort/busy_acc0", 32'(busy_a), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort/ready", 32'(rdy_a), 32'd1);
    chk("abort/busy", 32'(busy_a), 32'd0);
    chk("abort/resp_valid", 32'(rv_a), 32'd0);
    chk("abort/resp_rdata", rd_a, 32'h0);
    chk("abort/resp_err", 32'(err_a), 32'd0);
    rstn = 1'b1;
    ld(0, 3'b000, 32'h20, 32'h3344A0A0, 2, "lw_20_after_abort");
    ld(0, 3'b000, 32'h24, 32'hB0B0B0B0, 2, "lw_24_after_abort");
    ld(0, 3'b000, 32'h10, 32'h3499AABB, 2, "lw_10_retained");
    wait_drain("post_abort");

    // Valid with neither re nor we: must stay ready and produce no response.
    @(negedge clk);
    sel        = 1'b0;
    req_valid  = 1'b1;
    req_re     = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("noop/ready", 32'(rdy_a), 32'd1);
    end
    ld(0, 3'b000, 32'h10, 32'h3499AABB, 2, "lw_10_after_noop");
    wait_drain("final");
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
